// File: rtl/unit_test_monitor.sv
// Watches a unitTest CPU's debug pc and result line, tallies passing/failing checks,
// and declares the run finished on halt (pc stuck) or on a cycle-count timeout.
module unit_test_monitor #(
  parameter int ADDR_WIDTH  = 10,
  parameter int STALL_LIMIT = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  result,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  done,
  output logic                  pass,
  output logic                  halted,
  output logic                  timeout,
  output logic [7:0]            pass_count,
  output logic [7:0]            fail_count,
  output logic [ADDR_WIDTH-1:0] last_fail_pc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0]  STALL_LIM_V = 4'(STALL_LIMIT);
  localparam logic [15:0] TIMEOUT_V   = 16'(TIMEOUT);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] prev_pc;
  logic [3:0]            stall_cnt;
  logic [15:0]           cycle_cnt;

  logic        in_run;
  logic        check;
  logic [3:0]  stall_inc;
  logic [15:0] cycle_inc;
  logic        hit_halt;
  logic        hit_timeout;
  logic [7:0]  pass_count_nxt;
  logic [7:0]  fail_count_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  // Next-cycle decisions for the current RUN cycle; halt takes priority over timeout.
  always_comb begin
    in_run         = (state == RUN);
    check          = in_run && (pc != prev_pc);
    stall_inc      = stall_cnt + 4'd1;
    cycle_inc      = cycle_cnt + 16'd1;
    hit_halt       = in_run && !check && (stall_inc == STALL_LIM_V);
    hit_timeout    = in_run && !hit_halt && (cycle_inc == TIMEOUT_V);
    pass_count_nxt = pass_count;
    fail_count_nxt = fail_count;
    if (check) begin
      if (result) pass_count_nxt = sat_inc8(pass_count);
      else        fail_count_nxt = sat_inc8(fail_count);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      prev_pc      <= '0;
      stall_cnt    <= '0;
      cycle_cnt    <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
      pass_count   <= '0;
      fail_count   <= '0;
      last_fail_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          prev_pc <= pc;
          state   <= RUN;
        end
        RUN: begin
          cycle_cnt  <= cycle_inc;
          prev_pc    <= pc;
          pass_count <= pass_count_nxt;
          fail_count <= fail_count_nxt;
          if (check) begin
            stall_cnt <= '0;
            if (!result) last_fail_pc <= pc;
          end else begin
            stall_cnt <= stall_inc;
          end
          if (hit_halt) begin
            state  <= DONE;
            done   <= 1'b1;
            halted <= 1'b1;
            pass   <= (fail_count_nxt == 8'd0) && (pass_count_nxt != 8'd0);
          end else if (hit_timeout) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        DONE: begin
          // Absorbing: everything holds until reset.
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unit_test_monitor.sv
// Self-checking bench: directed scenario table, hand-written reset sequence, and random
// stimulus compared every cycle against a rule-level reference model.
module tb_unit_test_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       result = 1'b1;
  logic [9:0] pc = '0;

  logic [2:0] done_w, pass_w, halt_w, to_w;
  logic [7:0] pcnt_w [3];
  logic [7:0] fcnt_w [3];
  logic [9:0] lf_w   [3];

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  unit_test_monitor #(.ADDR_WIDTH(10), .STALL_LIMIT(4), .TIMEOUT(64)) u0 (
    .clk(clk), .reset(reset), .result(result), .pc(pc),
    .done(done_w[0]), .pass(pass_w[0]), .halted(halt_w[0]), .timeout(to_w[0]),
    .pass_count(pcnt_w[0]), .fail_count(fcnt_w[0]), .last_fail_pc(lf_w[0]));

  unit_test_monitor #(.ADDR_WIDTH(10), .STALL_LIMIT(4), .TIMEOUT(8)) u1 (
    .clk(clk), .reset(reset), .result(result), .pc(pc),
    .done(done_w[1]), .pass(pass_w[1]), .halted(halt_w[1]), .timeout(to_w[1]),
    .pass_count(pcnt_w[1]), .fail_count(fcnt_w[1]), .last_fail_pc(lf_w[1]));

  unit_test_monitor #(.ADDR_WIDTH(10), .STALL_LIMIT(4), .TIMEOUT(1000)) u2 (
    .clk(clk), .reset(reset), .result(result), .pc(pc),
    .done(done_w[2]), .pass(pass_w[2]), .halted(halt_w[2]), .timeout(to_w[2]),
    .pass_count(pcnt_w[2]), .fail_count(fcnt_w[2]), .last_fail_pc(lf_w[2]));

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input string tag, input int i, input int e_done, input int e_pass,
                          input int e_halt, input int e_to, input int e_pc, input int e_fc,
                          input int e_lf);
    chk({tag, ".done"},         int'(done_w[i]), e_done);
    chk({tag, ".pass"},         int'(pass_w[i]), e_pass);
    chk({tag, ".halted"},       int'(halt_w[i]), e_halt);
    chk({tag, ".timeout"},      int'(to_w[i]),   e_to);
    chk({tag, ".pass_count"},   int'(pcnt_w[i]), e_pc);
    chk({tag, ".fail_count"},   int'(fcnt_w[i]), e_fc);
    chk({tag, ".last_fail_pc"}, int'(lf_w[i]),   e_lf);
  endtask

  // Reference model: the test's story told in plain integers.
  typedef struct {
    bit started, fin, halt, to;
    int prev, cycles, stall, pcnt, fcnt, lf;
  } mstate_t;

  mstate_t m [3];
  int lims [3] = '{64, 8, 1000};

  function automatic int min255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic mstate_t step(input mstate_t s, input int pcv, input bit res, input int lim);
    mstate_t n;
    n = s;
    if (!s.started) begin
      n.started = 1'b1;
      n.prev = pcv;
    end else if (!s.fin) begin
      n.cycles = s.cycles + 1;
      if (pcv != s.prev) begin
        n.stall = 0;
        if (res) n.pcnt = min255(s.pcnt + 1);
        else begin
          n.fcnt = min255(s.fcnt + 1);
          n.lf = pcv;
        end
      end else begin
        n.stall = s.stall + 1;
      end
      n.prev = pcv;
      if (n.stall == 4) begin
        n.fin = 1'b1;
        n.halt = 1'b1;
      end else if (n.cycles == lim) begin
        n.fin = 1'b1;
        n.to = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset) m[i] <= '{default: 0};
      else        m[i] <= step(m[i], int'(pc), result, lims[i]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk_inst($sformatf("model[%0d]", i), i, int'(m[i].fin),
                 int'(m[i].fin && m[i].halt && m[i].fcnt == 0 && m[i].pcnt != 0),
                 int'(m[i].halt), int'(m[i].to), m[i].pcnt, m[i].fcnt, m[i].lf);
      end
    end
  end

  typedef struct {
    int inst, lead, n_inc;
    logic [63:0] mask;
    bit all_fail;
    int hold;
    int e_done, e_pass, e_halt, e_to, e_pc, e_fc, e_lf;
  } vec_t;

  vec_t tbl [9];

  // Reset, IDLE at pc=0, `lead` RUN cycles still at 0, then pc=1..n_inc, then hold.
  task automatic run_vec(input vec_t v, input int idx);
    reset = 1'b0;
    pc = '0;
    result = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < v.lead; k++) @(negedge clk);
    for (int k = 1; k <= v.n_inc; k++) begin
      pc = 10'(k);
      result = v.all_fail ? 1'b0 : ((k < 64) ? !v.mask[k] : 1'b1);
      @(negedge clk);
    end
    result = 1'b1;
    for (int k = 0; k < v.hold; k++) @(negedge clk);
    chk_inst($sformatf("vec%0d", idx), v.inst, v.e_done, v.e_pass, v.e_halt, v.e_to,
             v.e_pc, v.e_fc, v.e_lf);
  endtask

  initial begin
    tbl[0] = '{0, 0, 5,   64'h0,  0, 4, 1, 1, 1, 0, 5,   0,   0};
    tbl[1] = '{0, 0, 5,   64'h0,  0, 3, 0, 0, 0, 0, 5,   0,   0};
    tbl[2] = '{0, 0, 6,   64'h28, 0, 4, 1, 0, 1, 0, 4,   2,   5};
    tbl[3] = '{0, 1, 70,  64'h0,  0, 0, 1, 0, 0, 1, 63,  0,   0};
    tbl[4] = '{0, 1, 62,  64'h0,  0, 0, 0, 0, 0, 0, 62,  0,   0};
    tbl[5] = '{1, 0, 4,   64'h0,  0, 4, 1, 1, 1, 0, 4,   0,   0};
    tbl[6] = '{1, 0, 10,  64'h0,  0, 0, 1, 0, 0, 1, 8,   0,   0};
    tbl[7] = '{2, 0, 300, 64'h0,  0, 0, 0, 0, 0, 0, 255, 0,   0};
    tbl[8] = '{2, 0, 300, 64'h0,  1, 0, 0, 0, 0, 0, 0,   255, 300};

    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) chk_inst($sformatf("rst[%0d]", i), i, 0, 0, 0, 0, 0, 0, 0);

    for (int t = 0; t < 9; t++) run_vec(tbl[t], t);

    // Asynchronous reset between edges with three failures recorded.
    reset = 1'b0;
    pc = '0;
    result = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      pc = 10'(k);
      result = (k > 3);
      @(negedge clk);
    end
    chk("async.pre_fail_count", int'(fcnt_w[0]), 3);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk_inst($sformatf("async[%0d]", i), i, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    pc = '0;
    result = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    pc = 10'd1;
    @(negedge clk);
    pc = 10'd2;
    @(negedge clk);
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk_inst("fresh", 0, 1, 1, 1, 0, 2, 0, 0);

    // Random episodes: narrow pc range so holds, repeats and stalls are common.
    for (int ep = 0; ep < 30; ep++) begin
      reset = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
      pc = 10'($urandom_range(0, 7));
      reset = 1'b1;
      for (int c = 0; c < int'($urandom_range(5, 120)); c++) begin
        if ($urandom_range(0, 9) >= 5) pc = 10'($urandom_range(0, 7));
        result = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unit_test_monitor.md
UNIT_TEST_MONITOR -- requirements
Module: unit_test_monitor

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10: width of the observed program counter.
REQ-002 The block SHALL have parameter STALL_LIMIT, default 4: consecutive cycles of unchanged pc that mean the CPU has halted (range 2..15).
REQ-003 The block SHALL have parameter TIMEOUT, default 64: maximum RUN cycles before a forced stop (range 2..65535).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-006 The block SHALL have port result, input, 1 bit: test outcome from the unitTest CPU (1 = pass, 0 = fail).
REQ-007 The block SHALL have port pc, input, ADDR_WIDTH bits: the CPU's debug program counter.
REQ-008 The block SHALL have port done, output, 1 bit: the run has finished.
REQ-009 The block SHALL have port pass, output, 1 bit: the run finished successfully.
REQ-010 The block SHALL have port halted, output, 1 bit: the run ended by halt detection.
REQ-011 The block SHALL have port timeout, output, 1 bit: the run ended by TIMEOUT.
REQ-012 The block SHALL have port pass_count, output, 8 bits: number of checks that passed.
REQ-013 The block SHALL have port fail_count, output, 8 bits: number of checks that failed.
REQ-014 The block SHALL have port last_fail_pc, output, ADDR_WIDTH bits: the pc of the most recent failing check.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-016 IDLE SHALL last exactly one cycle after reset deassertion: capture prev_pc <= pc, then go to RUN; no check occurs in IDLE.
REQ-017 In RUN, each cycle SHALL increment cycle_cnt, which is 16 bits and cleared on reset.
REQ-018 A check SHALL occur in a RUN cycle exactly when pc != prev_pc; prev_pc SHALL update to pc every RUN cycle.
REQ-019 On a check, if result=1 then pass_count SHALL increment; if result=0 then fail_count SHALL increment and last_fail_pc SHALL load pc.
REQ-020 pass_count and fail_count SHALL saturate at 255 and never wrap.
REQ-021 stall_cnt SHALL clear on a check and increment when pc == prev_pc.
REQ-022 When the incremented stall_cnt equals STALL_LIMIT, next state SHALL be DONE with halted=1.
REQ-023 When the incremented cycle_cnt equals TIMEOUT and no halt occurs that cycle, next state SHALL be DONE with timeout=1.
REQ-024 When halt and timeout occur in the same cycle, halt SHALL win: halted=1, timeout=0.
REQ-025 A check in the TIMEOUT cycle SHALL still be counted before the block enters DONE.
REQ-026 done SHALL be 1 exactly while in DONE; done SHALL assert one cycle after the terminating RUN cycle.
REQ-027 pass SHALL equal done & halted & (fail_count==0) & (pass_count!=0).
REQ-028 DONE SHALL be absorbing: all outputs frozen and all inputs ignored until reset.

Reset
REQ-029 Reset asserted (reset=0) SHALL immediately, without waiting for clk, force IDLE and clear done, pass, halted, timeout, pass_count, fail_count, last_fail_pc, prev_pc, stall_cnt and cycle_cnt to 0.
REQ-030 Reset asserted mid-RUN or in DONE SHALL discard all counts.
REQ-031 After reset deassertion, the block SHALL restart from IDLE per REQ-016.

Verification
REQ-032 The bench SHALL drive pc 0,1,2,3,4,5 with result=1, then hold pc=5 -> pass_count=5, fail_count=0, done at 4th stall cycle+1, halted=1, pass=1.
REQ-033 The bench SHALL drive pc 0..6 with result=0 at pc=3 and pc=5, then hold -> fail_count=2, last_fail_pc=5, pass_count=4, pass=0, halted=1.
REQ-034 The bench SHALL increment pc every cycle forever with result=1 (TIMEOUT=64) -> done after 64 RUN cycles, timeout=1, halted=0, pass=0, pass_count=63.
REQ-035 The bench SHALL set TIMEOUT=8, STALL_LIMIT=4 and drive pc changing 4 cycles then frozen -> halt and timeout coincide at RUN cycle 8; halted=1, timeout=0.
REQ-036 The bench SHALL run 300 passing checks with TIMEOUT=1000 -> pass_count saturates at 255.
REQ-037 The bench SHALL pull reset low asynchronously mid-RUN (between clk edges) with fail_count=3 -> all outputs read 0 before the next edge; after release the block runs a fresh test.
